fetch_unit: RTL and testbench

- Instruction-fetch stage: holds the PC, issues instruction-memory reads and registers the returned instruction.
- Presents op_o directly to the main decoder's op_i; the rest of instr_o feeds the immediate and register-file logic.
- Consumes the decoder's branch/jump outputs, combined with the ALU zero flag, to redirect the PC.
- Supports hazard stall, redirect flush and variable-latency memory with one outstanding read.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem reads and the
// instruction register that feeds decode.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  branch_i,
    input  logic                  jump_i,
    input  logic                  zero_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [31:0]           imem_rdata_i,
    output logic [31:0]           instr_o,
    output logic [6:0]            op_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  instr_valid_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_fetch_pc;
    logic [ADDR_WIDTH-1:0]   w_fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [31:0]             r_instr;
    logic                    r_valid;
    logic                    w_redirect;
    logic                    w_slot_free;
    logic                    w_req;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic [ADDR_WIDTH-1:0]   w_pc_inc;
    logic                    w_unused;

    assign w_redirect  = jump_i | (branch_i & zero_i);
    assign w_target    = {target_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_slot_free = !r_valid | !stall_i;
    assign w_pc_inc    = r_fetch_pc + PC_STEP;
    assign w_unused    = ^target_i[1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req          = 1'b0;
        w_accept       = 1'b0;
        unique case (r_state)
            ST_REQ: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                end else if (w_slot_free) begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                    w_state_nxt    = imem_rvalid_i ? ST_REQ : ST_DISCARD;
                end else if (imem_rvalid_i) begin
                    w_accept       = 1'b1;
                    w_fetch_pc_nxt = w_pc_inc;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                end
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // Flush beats load beats hold; an accepted response always finds the slot empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_instr <= imem_rdata_i;
            r_pc    <= r_fetch_pc;
            r_valid <= 1'b1;
        end else if (r_valid && !stall_i) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign imem_req_o    = w_req & rst_n_i;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_o       = r_instr;
    assign op_o          = r_instr[6:0];
    assign pc_o          = r_pc;
    assign pc_plus4_o    = r_pc + PC_STEP;
    assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against
// a program-order model of fetch addresses and outstanding reads.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        branch_i = 1'b0;
    logic        jump_i = 1'b0;
    logic        zero_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;

    logic        req2;
    logic [31:0] addr2;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = 32'h0;
    logic [31:0] instr2;
    logic [6:0]  op2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic        valid2;

    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        late_v = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = 32'h0;
    int          lat = 1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rvalid_i = mem_rvalid | late_v;
    assign imem_rdata_i  = late_v ? 32'hDEAD_BEEF : mem_rdata;

    fetch_unit dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .branch_i(branch_i),
        .jump_i(jump_i), .zero_i(zero_i), .target_i(target_i),
        .stall_i(stall_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .op_o(op_o),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .instr_valid_o(instr_valid_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .branch_i(branch_i),
        .jump_i(jump_i), .zero_i(zero_i), .target_i(target_i),
        .stall_i(stall_i), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rv2), .imem_rdata_i(rd2), .instr_o(instr2),
        .op_o(op2), .pc_o(pc2), .pc_plus4_o(pc4_2),
        .instr_valid_o(valid2)
    );

    // Memory with programmable latency (>=1 cycle), one read in flight.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend <= 1'b0;
            mem_rvalid <= 1'b0;
            cnt <= 0;
        end else begin
            mem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata <= memf(maddr);
                    pend <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req_o) begin
                if (lat <= 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata <= memf(imem_addr_o);
                end else begin
                    pend <= 1'b1;
                    cnt <= lat - 1;
                    maddr <= imem_addr_o;
                end
            end
        end
    end

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rv2 <= 1'b0;
        end else begin
            rv2 <= req2;
            rd2 <= memf(addr2);
        end
    end

    task automatic apply_reset;
        rst_n_i = 1'b0;
        stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; zero_i = 1'b0;
        target_i = 32'h0; late_v = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_valid(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk_i);
            got = instr_valid_o;
        end
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        compared++; if (instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", instr_valid_o); end
        compared++; if (instr_o !== NOP) begin mismatched++; $display("FAIL reset_instr got %h want %h", instr_o, NOP); end
        compared++; if (pc_o !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h want 0", pc_o); end
        compared++; if (pc_plus4_o !== 32'h4) begin mismatched++; $display("FAIL reset_pc4 got %h want 4", pc_plus4_o); end
        compared++; if (op_o !== 7'h13) begin mismatched++; $display("FAIL reset_op got %h want 13", op_o); end
        compared++; if (imem_req_o !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    endtask

    task automatic test_first_fetch;
        logic [31:0] e;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        #1;
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin mismatched++; $display("FAIL first_req got %b/%h want 1/0", imem_req_o, imem_addr_o); end
        @(negedge clk_i);
        compared++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL first_wait got req %b valid %b want 0/0", imem_req_o, instr_valid_o); end
        @(negedge clk_i);
        #1;
        e = memf(32'h0);
        compared++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin mismatched++; $display("FAIL first_load got valid %b pc %h want 1/0", instr_valid_o, pc_o); end
        compared++; if (instr_o !== e) begin mismatched++; $display("FAIL first_instr got %h want %h", instr_o, e); end
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin mismatched++; $display("FAIL first_next_req got %b/%h want 1/4", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_sequential;
        int n = 0;
        int last = 0;
        bit pv = 1'b0;
        logic [31:0] ea;
        logic [31:0] e;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk_i);
            if (instr_valid_o && !pv) begin
                ea = 32'(4 * n);
                e = memf(ea);
                compared++; if (pc_o !== ea) begin mismatched++; $display("FAIL seq_pc got %h want %h", pc_o, ea); end
                compared++; if (instr_o !== e) begin mismatched++; $display("FAIL seq_instr got %h want %h", instr_o, e); end
                compared++; if (op_o !== e[6:0]) begin mismatched++; $display("FAIL seq_op got %h want %h", op_o, e[6:0]); end
                compared++; if (pc_plus4_o !== ea + 32'd4) begin mismatched++; $display("FAIL seq_pc4 got %h want %h", pc_plus4_o, ea + 32'd4); end
                if (n > 0) begin
                    compared++; if (cyc - last != 2) begin mismatched++; $display("FAIL seq_rate got %0d want 2", cyc - last); end
                end
                last = cyc;
                n++;
            end
            pv = instr_valid_o;
        end
        compared++; if (n != 4) begin mismatched++; $display("FAIL seq_count got %0d want 4", n); end
    endtask

    task automatic test_stall;
        bit got;
        logic [31:0] hi;
        logic [31:0] hp;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        wait_valid(20, got);
        compared++; if (!got) begin mismatched++; $display("FAIL stall_first got 0 want 1"); end
        hi = instr_o;
        hp = pc_o;
        stall_i = 1'b1;
        #1;
        compared++; if (imem_req_o !== 1'b0) begin mismatched++; $display("FAIL stall_req0 got %b want 0", imem_req_o); end
        repeat (2) begin
            @(negedge clk_i);
            #1;
            compared++; if (instr_valid_o !== 1'b1 || instr_o !== hi || pc_o !== hp) begin mismatched++; $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h", instr_valid_o, instr_o, pc_o, hi, hp); end
            compared++; if (imem_req_o !== 1'b0) begin mismatched++; $display("FAIL stall_req got %b want 0", imem_req_o); end
        end
        @(negedge clk_i);
        stall_i = 1'b0;
        #1;
        compared++; if (instr_valid_o !== 1'b1 || instr_o !== hi) begin mismatched++; $display("FAIL stall_last got %b/%h want 1/%h", instr_valid_o, instr_o, hi); end
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== hp + 32'd4) begin mismatched++; $display("FAIL stall_resume got %b/%h want 1/%h", imem_req_o, imem_addr_o, hp + 32'd4); end
        @(negedge clk_i);
        compared++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== hp) begin mismatched++; $display("FAIL stall_drain got %b/%h/%h want 0/%h/%h", instr_valid_o, instr_o, pc_o, NOP, hp); end
    endtask

    task automatic test_branch;
        bit got = 1'b0;
        logic [31:0] e;
        apply_reset;
        lat = 3;
        rst_n_i = 1'b1;
        #1;
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin mismatched++; $display("FAIL br_req got %b/%h want 1/0", imem_req_o, imem_addr_o); end
        @(negedge clk_i);
        branch_i = 1'b1; zero_i = 1'b1; target_i = 32'h40;
        @(negedge clk_i);
        branch_i = 1'b0; zero_i = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            #1;
            compared++; if (instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL br_drop got %b want 0", instr_valid_o); end
            got = imem_req_o;
        end
        compared++; if (!got || imem_addr_o !== 32'h40) begin mismatched++; $display("FAIL br_target got %b/%h want 1/40", got, imem_addr_o); end
        wait_valid(10, got);
        e = memf(32'h40);
        compared++; if (!got || pc_o !== 32'h40 || instr_o !== e) begin mismatched++; $display("FAIL br_load got %b/%h/%h want 1/40/%h", got, pc_o, instr_o, e); end
        apply_reset;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        branch_i = 1'b1; zero_i = 1'b0; target_i = 32'h40;
        @(negedge clk_i);
        branch_i = 1'b0;
        wait_valid(10, got);
        e = memf(32'h0);
        compared++; if (!got || pc_o !== 32'h0 || instr_o !== e) begin mismatched++; $display("FAIL nt_load got %b/%h/%h want 1/0/%h", got, pc_o, instr_o, e); end
        #1;
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin mismatched++; $display("FAIL nt_next got %b/%h want 1/4", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_jump_stall;
        bit got;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        wait_valid(20, got);
        compared++; if (!got) begin mismatched++; $display("FAIL js_first got 0 want 1"); end
        stall_i = 1'b1;
        @(negedge clk_i);
        jump_i = 1'b1;
        target_i = 32'h103;
        @(negedge clk_i);
        compared++; if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin mismatched++; $display("FAIL js_flush got %b/%h want 0/%h", instr_valid_o, instr_o, NOP); end
        jump_i = 1'b0;
        #1;
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin mismatched++; $display("FAIL js_req got %b/%h want 1/100", imem_req_o, imem_addr_o); end
        stall_i = 1'b0;
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        apply_reset;
        rst_n_i = 1'b1;
        #1;
        compared++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_req1 got %b/%h want 1/fffffffc", req2, addr2); end
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        e = memf(32'hFFFF_FFFC);
        compared++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== e) begin mismatched++; $display("FAIL wrap_load got %b/%h/%h want 1/fffffffc/%h", valid2, pc2, instr2, e); end
        compared++; if (pc4_2 !== 32'h0) begin mismatched++; $display("FAIL wrap_pc4 got %h want 0", pc4_2); end
        compared++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin mismatched++; $display("FAIL wrap_req2 got %b/%h want 1/0", req2, addr2); end
    endtask

    task automatic test_reset_mid_wait;
        bit got;
        logic [31:0] e;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        jump_i = 1'b1;
        target_i = 32'h80;
        @(negedge clk_i);
        jump_i = 1'b0;
        wait_valid(20, got);
        compared++; if (!got || pc_o !== 32'h80) begin mismatched++; $display("FAIL rw_pre got %b/%h want 1/80", got, pc_o); end
        lat = 4;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        compared++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin mismatched++; $display("FAIL rw_reset got %b/%h/%h/%b want 0/%h/0/0", instr_valid_o, instr_o, pc_o, imem_req_o, NOP); end
        @(negedge clk_i);
        lat = 2;
        rst_n_i = 1'b1;
        late_v = 1'b1;
        #1;
        compared++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin mismatched++; $display("FAIL rw_req got %b/%h want 1/0", imem_req_o, imem_addr_o); end
        @(negedge clk_i);
        late_v = 1'b0;
        compared++; if (instr_valid_o !== 1'b0) begin mismatched++; $display("FAIL rw_late got %b want 0", instr_valid_o); end
        wait_valid(10, got);
        e = memf(32'h0);
        compared++; if (!got || pc_o !== 32'h0 || instr_o !== e) begin mismatched++; $display("FAIL rw_load got %b/%h/%h want 1/0/%h", got, pc_o, instr_o, e); end
    endtask

    task automatic test_random;
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] e;
        logic [31:0] o_instr = NOP;
        logic [31:0] o_pc = 32'h0;
        bit o_valid = 1'b0;
        bit cur_stall = 1'b0;
        bit cur_redir = 1'b0;
        bit out;
        bit rv_last = 1'b0;
        bit want;
        int unsigned r;
        int deliveries = 0;
        apply_reset;
        lat = 1;
        rst_n_i = 1'b1;
        #1;
        out = imem_req_o;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_i);
            if (cur_redir) begin
                compared++; if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin mismatched++; $display("FAIL rnd_flush got %b/%h want 0/%h", instr_valid_o, instr_o, NOP); end
            end else if (!o_valid && instr_valid_o) begin
                e = memf(exp_pc);
                compared++; if (pc_o !== exp_pc || instr_o !== e) begin mismatched++; $display("FAIL rnd_load got %h/%h want %h/%h", pc_o, instr_o, exp_pc, e); end
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end else if (o_valid && cur_stall) begin
                compared++; if (instr_valid_o !== 1'b1 || instr_o !== o_instr || pc_o !== o_pc) begin mismatched++; $display("FAIL rnd_hold got %b/%h/%h want 1/%h/%h", instr_valid_o, instr_o, pc_o, o_instr, o_pc); end
            end
            o_valid = instr_valid_o;
            o_instr = instr_o;
            o_pc = pc_o;
            stall_i = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            jump_i = (r == 0);
            branch_i = (r == 1 || r == 2);
            zero_i = (r == 1) || (r > 2 && $urandom_range(0, 1) == 1);
            target_i = $urandom;
            lat = int'($urandom_range(1, 4));
            cur_stall = stall_i;
            cur_redir = jump_i | (branch_i & zero_i);
            if (cur_redir) exp_pc = {target_i[31:2], 2'b00};
            #1;
            if (rv_last) out = 1'b0;
            want = !out && !cur_redir && (!instr_valid_o || !cur_stall);
            compared++; if (imem_req_o !== want) begin mismatched++; $display("FAIL rnd_req got %b want %b", imem_req_o, want); end
            if (imem_req_o) begin
                compared++; if (imem_addr_o !== exp_pc) begin mismatched++; $display("FAIL rnd_addr got %h want %h", imem_addr_o, exp_pc); end
            end
            out = out | imem_req_o;
            rv_last = imem_rvalid_i;
        end
        compared++; if (deliveries < 40) begin mismatched++; $display("FAIL rnd_progress got %0d want >=40", deliveries); end
        stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; zero_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_sequential;
        test_stall;
        test_branch;
        test_jump_stall;
        test_wrap;
        test_reset_mid_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
